// File: rtl/qmath_pkg.sv
//==============================================================================
// Module      : qmath_pkg
// Description : Shared constants, state encoding and width helper for the
//               fixed-point math library (qmult / qdiv_seq).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package qmath_pkg;

    localparam int c_DEFAULT_Q = 16;
    localparam int c_DEFAULT_N = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of the pre-shifted dividend magnitude and of the full quotient.
    function automatic int qdiv_width(input int q, input int n);
        return n - 1 + q;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qdiv_step.sv
//==============================================================================
// Module      : qdiv_step
// Description : One restoring-division step: shift in a dividend bit, compare
//               against the divisor, conditionally subtract.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module qdiv_step #(
    parameter int MW = 31
) (
    input  logic [MW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [MW-1:0] i_dvs,
    output logic [MW-1:0] o_rem,
    output logic          o_qbit
);

    logic [MW:0] w_shifted;
    logic [MW:0] w_diff;
    logic        w_unused_msb;

    // Both candidate remainders are below the divisor, so their MSB is always 0.
    assign w_shifted    = {i_rem, i_bit};
    assign w_diff       = w_shifted - {1'b0, i_dvs};
    assign o_qbit       = (w_shifted >= {1'b0, i_dvs});
    assign o_rem        = o_qbit ? w_diff[MW-1:0] : w_shifted[MW-1:0];
    assign w_unused_msb = w_diff[MW] ^ w_shifted[MW];

endmodule

`default_nettype wire

// File: rtl/qdiv_seq.sv
//==============================================================================
// Module      : qdiv_seq
// Description : Sequential sign-magnitude Q-format divider, one quotient bit
//               per clock, with saturation and divide-by-zero flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module qdiv_seq
    import qmath_pkg::*;
#(
    parameter int Q = c_DEFAULT_Q,
    parameter int N = c_DEFAULT_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_complete,
    output logic         o_busy,
    output logic         o_ovr,
    output logic         o_div0
);

    localparam int W  = qdiv_width(Q, N);
    localparam int MW = N - 1;
    localparam int CW = $clog2(W + 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_dvd;
    logic [W-1:0]    r_quo;
    logic [MW-1:0]   r_rem;
    logic [MW-1:0]   r_dvs;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_div0;
    logic            r_hold;
    logic [N-1:0]    r_quotient;
    logic            r_complete;
    logic            r_ovr;
    logic            r_div0_out;

    logic            w_dvs_zero;
    logic [MW-1:0]   w_rem_next;
    logic            w_qbit;
    logic            w_quo_ovr;
    logic            w_res_ovr;
    logic [MW-1:0]   w_res_mag;
    logic            w_res_sign;

    assign w_dvs_zero = (i_divisor[N-2:0] == '0);

    qdiv_step #(
        .MW (MW)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[W-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    // Quotient bits above the magnitude field cannot be represented.
    assign w_quo_ovr  = |r_quo[W-1:MW];
    assign w_res_ovr  = r_div0 | w_quo_ovr;
    assign w_res_mag  = w_res_ovr ? {MW{1'b1}} : r_quo[MW-1:0];
    assign w_res_sign = (w_res_mag == '0) ? 1'b0 : r_sign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = w_dvs_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!r_hold) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dvd      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_div0     <= 1'b0;
            r_hold     <= 1'b0;
            r_quotient <= '0;
            r_complete <= 1'b0;
            r_ovr      <= 1'b0;
            r_div0_out <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dvs  <= i_divisor[N-2:0];
                        r_dvd  <= W'(i_dividend[N-2:0]) << Q;
                        r_rem  <= '0;
                        r_quo  <= '0;
                        r_cnt  <= CW'(W);
                        r_div0 <= w_dvs_zero;
                        // Divide-by-zero idles one extra cycle in DONE for a fixed latency.
                        r_hold <= w_dvs_zero;
                        r_sign <= w_dvs_zero ? i_dividend[N-1]
                                             : (i_dividend[N-1] ^ i_divisor[N-1]);
                    end
                end
                S_CALC: begin
                    r_dvd <= r_dvd << 1;
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[W-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_DONE: begin
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else begin
                        r_quotient <= {w_res_sign, w_res_mag};
                        r_ovr      <= w_res_ovr;
                        r_div0_out <= r_div0;
                        r_complete <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient = r_quotient;
    assign o_complete = r_complete;
    assign o_ovr      = r_ovr;
    assign o_div0     = r_div0_out;
    assign o_busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_qdiv_seq.sv
//==============================================================================
// Module      : tb_qdiv_seq
// Description : Scoreboard bench for qdiv_seq with directed, hand-computed
//               vectors; a monitor checks every completion against the queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_qdiv_seq;

    localparam int c_N   = 32;
    localparam int c_LAT = 48;

    typedef struct {
        logic [31:0] quot;
        logic        ovr;
        logic        div0;
        int          lat;
        int          k;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic        complete;
    logic        busy;
    logic        ovr;
    logic        div0;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    qdiv_seq #(
        .Q (16),
        .N (c_N)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_quotient (quotient),
        .o_complete (complete),
        .o_busy     (busy),
        .o_ovr      (ovr),
        .o_div0     (div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (complete) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_complete: got quotient 0x%08h with no pending request (cycle %0d)",
                         quotient, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_quot"}, quotient, e.quot);
                chk({e.name, "_ovr"}, 32'(ovr), 32'(e.ovr));
                chk({e.name, "_div0"}, 32'(div0), 32'(e.div0));
                chk({e.name, "_lat"}, 32'(cyc - e.k), 32'(e.lat));
                chk({e.name, "_busy_low"}, 32'(busy), 32'd0);
            end
        end
    end

    // Caller is at a negedge; the start is accepted at the following posedge.
    task automatic start_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] q, input logic f_ovr, input logic f_div0,
                            input int lat, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
        chk({nm, "_busy_high"}, 32'(busy), 32'd1);
        if (push) begin
            e.quot = q;
            e.ovr  = f_ovr;
            e.div0 = f_div0;
            e.lat  = lat;
            e.k    = cyc;
            e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy && !complete) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic f_ovr, input logic f_div0,
                          input int lat);
        @(negedge clk);
        start_op(nm, a, b, q, f_ovr, f_div0, lat, 1'b1);
        wait_idle(nm);
    endtask

    initial begin
        int k;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_quot", quotient, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_flags", {30'd0, ovr, div0}, 32'd0);

        run_op("six_by_two",  32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, c_LAT);
        run_op("neg_1p5",     32'h8001_8000, 32'h0000_8000, 32'h8003_0000, 1'b0, 1'b0, c_LAT);
        run_op("one_third",   32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, c_LAT);
        run_op("overflow",    32'h4000_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b1, 1'b0, c_LAT);
        run_op("div_by_zero", 32'h8005_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 2);
        run_op("neg_zero",    32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, c_LAT);
        run_op("after_zero",  32'h8007_0000, 32'h0002_0000, 32'h8003_8000, 1'b0, 1'b0, c_LAT);

        // Back-to-back: second start lands in the completion cycle of the first.
        @(negedge clk);
        start_op("b2b_first", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, c_LAT, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (complete) seen = 1'b1;
        end
        chk("b2b_first_seen", 32'(seen), 32'd1);
        start_op("b2b_second", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, c_LAT, 1'b1);
        wait_idle("b2b");

        // Abort: start, ignored start at k+10, reset at k+20, new start at k+22.
        @(negedge clk);
        start_op("abort_op", 32'h0007_0000, 32'h0002_0000, 32'h0, 1'b0, 1'b0, c_LAT, 1'b0);
        k = cyc;
        while (cyc < k + 9) @(negedge clk);
        dividend = 32'h0009_0000;
        divisor  = 32'h0003_0000;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        while (cyc < k + 19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_quot", quotient, 32'h0);
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_cmp", 32'(complete), 32'd0);
        chk("abort_rst_flags", {30'd0, ovr, div0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_op("after_abort", 32'h8007_0000, 32'h0002_0000, 32'h8003_8000, 1'b0, 1'b0, c_LAT, 1'b1);
        chk("after_abort_start_cycle", 32'(cyc - k), 32'd22);
        wait_idle("after_abort");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/qdiv_seq.md
# qdiv_seq

Sequential signed-magnitude fixed-point divider, the inverse operation to the team's combinational `qmult` multiplier. It uses the same (Q, N) number format: bit N-1 is the sign, and bits N-2:0 are the magnitude with Q fractional bits. It computes dividend / divisor by restoring shift-subtract, producing one quotient bit per clock, under a start/complete handshake. It sits beside `qmult` in the fixed-point math library and feeds normalisation and scaling paths that cannot afford a combinational divide.

## Interface
Parameters:
- `Q`, 16, number of fractional bits
- `N`, 32, total word width including the sign bit

Ports:
- `i_clk`  in  1  clock; single clock domain
- `i_rst`  in  1  reset; synchronous, active-high
- `i_start`  in  1  request; sampled only in IDLE
- `i_dividend`  in  N  sign-magnitude dividend; captured at accepted start
- `i_divisor`  in  N  sign-magnitude divisor; captured at accepted start
- `o_quotient`  out  N  sign-magnitude result; holds until the next completion
- `o_complete`  out  1  one-cycle pulse; the result and flags are valid
- `o_busy`  out  1  high while a division is in progress
- `o_ovr`  out  1  result saturated; valid with `o_complete`, held until the next completion
- `o_div0`  out  1  divisor magnitude was zero; valid with `o_complete`, held until the next completion

## Operation
- The state machine has three states: IDLE, CALC and DONE.
- IDLE with `i_start=1`:
  - Capture both operands.
  - Set the sign register to `i_dividend[N-1]` XOR `i_divisor[N-1]`.
  - Load the working dividend as magnitude << Q, which is W = N-1+Q bits wide.
  - Clear the partial remainder. Load the iteration counter with W.
  - Go to CALC.
- IDLE, divide by zero: if the divisor magnitude (bits N-2:0) is 0, skip CALC and go straight to DONE.
  - Result: sign = dividend sign, magnitude all ones.
  - `o_div0=1`, `o_ovr=1`.
- CALC: each cycle, perform one restoring step.
  - Shift the next dividend MSB into the remainder.
  - If remainder ≥ divisor magnitude, subtract and shift a 1 into the quotient; otherwise shift a 0.
  - Decrement the counter. When the counter reaches 1, go to DONE.
- Width rules:
  - The full quotient is W bits wide.
  - Overflow occurs if any of bits W-1:N-1 are set. The magnitude then saturates to all ones, the sign is preserved, and `o_ovr=1`.
  - Otherwise the magnitude is bits N-2:0 of the quotient.
  - Rounding is truncation toward zero. The remainder is discarded.
- Negative zero:
  - A zero result magnitude forces sign 0.
  - A dividend of ±0 yields +0 with no flags.
- DONE:
  - Register `o_quotient`, `o_ovr` and `o_div0`.
  - Pulse `o_complete`.
  - Go to IDLE.
- `i_start` is ignored while in CALC or DONE. The operand inputs may change freely after capture.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. This applies in any state, including mid-CALC.
  - A reset mid-operation aborts the division.
  - No `o_complete` pulse is emitted for the aborted operation.
- Normal latency, with the start accepted at edge k:
  - `o_busy=1` from edge k+1 until edge k+N+Q.
  - `o_complete=1` for exactly the one cycle following edge k+N+Q. For defaults this is 48 cycles.
- Divide-by-zero latency: `o_complete` is high for the cycle following edge k+2.
- `o_busy` is 0 during the `o_complete` cycle.
  - A start asserted in that same cycle is accepted, so back-to-back operations have a throughput of N+Q cycles each.
- `o_quotient`, `o_ovr` and `o_div0` change only at the edge that raises `o_complete`.

## Structure
- Shared package `qmath_pkg` holds:
  - the state enum (IDLE/CALC/DONE);
  - the default Q/N constants;
  - a width helper for W.
  - `qmult` users share the same constants.
- The datapath fits in one module.
- An optional combinational sub-module, `qdiv_step`, performs one compare/subtract/shift. It keeps CALC readable and allows future unrolling to 2 bits per cycle.
- Estimated size: about 150–250 RTL lines.

## Test plan
- `0x00060000 / 0x00020000` (6.0/2.0) -> `o_quotient=0x00030000`, flags 0, `o_complete` exactly 48 cycles after the start edge.
- `0x80018000 / 0x00008000` (-1.5/0.5) -> `0x80030000`. Also `0x00010000 / 0x00030000` (1/3) -> `0x00005555` (truncated).
- `0x40000000 / 0x00000100` (16384/(1/256)) -> `0x7FFFFFFF`, `o_ovr=1`, `o_div0=0`.
- `0x80050000 / 0x80000000` (divisor -0) -> `0xFFFFFFFF`, `o_div0=1`, `o_ovr=1`, `o_complete` in the cycle after edge k+2.
- Start accepted, `i_start` pulsed with new operands at cycle k+10, then `i_rst` at k+20 -> no `o_complete`, all outputs 0. A new start at k+22 completes correctly with the new operands.
- Start asserted during the `o_complete` cycle -> second result follows N+Q cycles later.
- `0x80000000 / 0x00010000` (-0/1.0) -> `0x00000000`, no flags.
